qcw_ramp_sequencer: RTL and testbench

- Drives the bridge oscillator's load/enable interface for one QCW burst.
- Measures the resonant feedback period from the zero-crossing comparator and reloads period_value every oscillator period, on period_done.
- Ramps phase_shift linearly from zero over a programmed number of periods, then disables the oscillator and enforces a cooldown before the next burst.

---
 rtl/qcw_ramp_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_qcw_ramp_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qcw_ramp_sequencer.sv
// QCW burst sequencer: tracks the resonant feedback period and ramps the bridge
// phase shift over a programmed number of oscillator periods, then cools down.
module qcw_ramp_sequencer #(
  parameter int MIN_PERIOD     = 200,
  parameter int MAX_PERIOD     = 4000,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int GRACE_PERIODS  = 4,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  ramp_rate,
  input  logic [15:0] ramp_cycles,
  input  logic        feedback,
  input  logic        period_done,
  output logic        enable,
  output logic        load,
  output logic [11:0] period_value,
  output logic [7:0]  phase_shift,
  output logic        busy,
  output logic        fault
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_STOP,
    S_COOLDOWN
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        fb_pipe_q;
  logic              fb_edge;
  logic [12:0]       fb_cnt_q, fb_cnt_d;
  logic [13:0]       fb_cnt_inc;
  logic              meas_in_range;
  logic [11:0]       meas_period_q, meas_period_d;
  logic              meas_valid_q, meas_valid_d;
  logic              fb_lost;

  logic              enable_q, enable_d;
  logic              load_q, load_d;
  logic [11:0]       period_q, period_d;
  logic [7:0]        phase_q, phase_d;
  logic [15:0]       cyc_cnt_q, cyc_cnt_d;
  logic [HOLD_W-1:0] holdoff_cnt_q, holdoff_cnt_d;
  logic              fault_q, fault_d;

  logic              start_accept;
  logic [8:0]        phase_sum;
  logic [7:0]        phase_sat;
  logic [15:0]       ramp_last;
  logic              fault_cond;

  // Two synchroniser flops plus one history flop for the rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_pipe_q <= 3'b000;
    end else begin
      fb_pipe_q <= {fb_pipe_q[1:0], feedback};
    end
  end

  assign fb_edge       = fb_pipe_q[1] & ~fb_pipe_q[2];
  assign fb_cnt_inc    = {1'b0, fb_cnt_q} + 14'd1;
  assign meas_in_range = (fb_cnt_inc >= 14'(MIN_PERIOD)) && (fb_cnt_inc <= 14'(MAX_PERIOD));
  assign fb_lost       = (fb_cnt_q >= 13'(2 * MAX_PERIOD));
  assign start_accept  = (state_q == S_IDLE) && start;

  always_comb begin
    fb_cnt_d      = fb_cnt_q;
    meas_period_d = meas_period_q;
    meas_valid_d  = meas_valid_q;
    if (fb_edge) begin
      fb_cnt_d = 13'd0;
      if (meas_in_range) begin
        meas_period_d = fb_cnt_inc[11:0];
        meas_valid_d  = 1'b1;
      end
    end else if (fb_cnt_q != 13'h1FFF) begin
      fb_cnt_d = fb_cnt_q + 13'd1;
    end
    // A fresh burst must not inherit a measurement taken while idle.
    if (start_accept) begin
      meas_valid_d = 1'b0;
    end
  end

  assign phase_sum  = {1'b0, phase_q} + {1'b0, ramp_rate};
  assign phase_sat  = phase_sum[8] ? 8'hFF : phase_sum[7:0];
  assign ramp_last  = (ramp_cycles == 16'd0) ? 16'd0 : (ramp_cycles - 16'd1);
  assign fault_cond = fb_lost && (cyc_cnt_q >= 16'(GRACE_PERIODS));

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    load_d        = 1'b0;
    period_d      = period_q;
    phase_d       = phase_q;
    cyc_cnt_d     = cyc_cnt_q;
    holdoff_cnt_d = holdoff_cnt_q;
    fault_d       = fault_q;
    case (state_q)
      S_IDLE: begin
        enable_d = 1'b0;
        if (start) begin
          period_d  = 12'(DEFAULT_PERIOD);
          phase_d   = 8'd0;
          load_d    = 1'b1;
          fault_d   = 1'b0;
          cyc_cnt_d = 16'd0;
          state_d   = S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        enable_d = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // Lost feedback takes priority over a coincident period wrap.
        if (fault_cond) begin
          fault_d  = 1'b1;
          enable_d = 1'b0;
          state_d  = S_STOP;
        end else if (period_done) begin
          if (cyc_cnt_q == ramp_last) begin
            enable_d = 1'b0;
            state_d  = S_STOP;
          end else begin
            load_d    = 1'b1;
            phase_d   = phase_sat;
            cyc_cnt_d = cyc_cnt_q + 16'd1;
            if (meas_valid_q) begin
              period_d = meas_period_q;
            end
          end
        end
      end
      S_STOP: begin
        holdoff_cnt_d = '0;
        state_d       = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        holdoff_cnt_d = holdoff_cnt_q + 1'b1;
        if (holdoff_cnt_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fb_cnt_q      <= 13'd0;
      meas_period_q <= 12'd0;
      meas_valid_q  <= 1'b0;
      enable_q      <= 1'b0;
      load_q        <= 1'b0;
      period_q      <= 12'(DEFAULT_PERIOD);
      phase_q       <= 8'd0;
      cyc_cnt_q     <= 16'd0;
      holdoff_cnt_q <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fb_cnt_q      <= fb_cnt_d;
      meas_period_q <= meas_period_d;
      meas_valid_q  <= meas_valid_d;
      enable_q      <= enable_d;
      load_q        <= load_d;
      period_q      <= period_d;
      phase_q       <= phase_d;
      cyc_cnt_q     <= cyc_cnt_d;
      holdoff_cnt_q <= holdoff_cnt_d;
      fault_q       <= fault_d;
    end
  end

  assign enable       = enable_q;
  assign load         = load_q;
  assign period_value = period_q;
  assign phase_shift  = phase_q;
  assign busy         = (state_q != S_IDLE);
  assign fault        = fault_q;

  // The oscillator may only be enabled while the ramp is running.
  a_enable_only_in_run: assert property (@(posedge clk) disable iff (rst)
    enable_q == (state_q == S_RUN));

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Scoreboard bench for qcw_ramp_sequencer: expected load transactions are queued
// by the stimulus and checked by an independent monitor on every load pulse.
module tb_qcw_ramp_sequencer;

  localparam int HOLD    = 300;
  localparam int MINP    = 200;
  localparam int MAXP    = 4000;
  localparam int DEFP    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ramp_rate = 8'd0;
  logic [15:0] ramp_cycles = 16'd0;
  logic        feedback = 1'b0;
  logic        period_done = 1'b0;
  logic        enable, load, busy, fault;
  logic [11:0] period_value;
  logic [7:0]  phase_shift;

  qcw_ramp_sequencer #(
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .DEFAULT_PERIOD(DEFP),
    .GRACE_PERIODS(4), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ramp_rate(ramp_rate),
    .ramp_cycles(ramp_cycles), .feedback(feedback), .period_done(period_done),
    .enable(enable), .load(load), .period_value(period_value),
    .phase_shift(phase_shift), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] per;
    logic [7:0]  ph;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // reference model state
  int   since_rise = 100000;
  bit   exp_valid = 0;
  int   exp_meas = 0;
  int   held_per = DEFP;
  int   acc = 0;
  int   rate = 0;
  int   rc = 1;
  int   pd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (since_rise < 100000) since_rise++;
  endtask

  task automatic do_start(input int rate_i, input int rc_i);
    ramp_rate   = 8'(rate_i);
    ramp_cycles = 16'(rc_i);
    rate      = rate_i;
    rc        = (rc_i == 0) ? 1 : rc_i;
    exp_valid = 0;
    held_per  = DEFP;
    acc       = 0;
    pd_cnt    = 0;
    q.push_back('{per: 12'(DEFP), ph: 8'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_load", int'(load), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_fault_clear", int'(fault), 0);
    chk("preload_enable", int'(enable), 0);
    tick();
    chk("run_enable", int'(enable), 1);
  endtask

  // One oscillator period: optional feedback pulse starting at offset 0,
  // optional period_done on the last cycle, optional stray start pulse.
  task automatic period(input int len, input bit pd, input bit fb, input int start_at);
    bit ended;
    for (int i = 0; i < len; i++) begin
      ended = 0;
      if (fb && i == 0) begin
        if (since_rise >= MINP && since_rise <= MAXP) begin
          exp_meas  = since_rise;
          exp_valid = 1;
        end
        since_rise = 0;
      end
      feedback    = fb && (i < len / 2);
      period_done = pd && (i == len - 1);
      start       = (i == start_at);
      if (period_done) begin
        if (pd_cnt == rc - 1) begin
          ended = 1;
        end else begin
          acc = (acc + rate > 255) ? 255 : acc + rate;
          if (exp_valid) held_per = exp_meas;
          q.push_back('{per: 12'(held_per), ph: 8'(acc)});
          pd_cnt++;
        end
      end
      tick();
      if (period_done) begin
        chk("enable_after_pd", int'(enable), ended ? 0 : 1);
        chk("fault_after_pd", int'(fault), 0);
      end
    end
    period_done = 1'b0;
    start       = 1'b0;
  endtask

  task automatic wait_idle(input bit exact, input int ign_start_at);
    int n;
    n = 0;
    while (busy && n < HOLD + 100) begin
      start = (n == ign_start_at);
      tick();
      n++;
    end
    start = 1'b0;
    if (exact) chk("busy_after_stop_cycles", n, HOLD + 1);
    chk("back_to_idle", int'(busy), 0);
  endtask

  // monitor / scoreboard
  logic        rst_at_edge;
  logic [11:0] prev_per;
  logic [7:0]  prev_ph;
  exp_t        e;

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (rst_at_edge === 1'b0) begin
      if (load) begin
        n_vec++;
        if (q.size() == 0) begin
          n_miss++;
          $display("FAIL load_unexpected: period_value=%0d phase_shift=%0d, no load expected",
                   period_value, phase_shift);
        end else begin
          e = q.pop_front();
          if (period_value !== e.per || phase_shift !== e.ph) begin
            n_miss++;
            $display("FAIL load_vector: got period_value=%0d phase_shift=%0d expected %0d/%0d",
                     period_value, phase_shift, e.per, e.ph);
          end else begin
            $display("load ok: period_value=%0d phase_shift=%0d", period_value, phase_shift);
          end
        end
      end else if (period_value !== prev_per || phase_shift !== prev_ph) begin
        n_vec++;
        n_miss++;
        $display("FAIL output_without_load: period_value %0d->%0d phase_shift %0d->%0d",
                 prev_per, period_value, prev_ph, phase_shift);
      end
    end
    prev_per = period_value;
    prev_ph  = phase_shift;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_enable", int'(enable), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_phase", int'(phase_shift), 0);
    chk("rst_period", int'(period_value), DEFP);
    rst = 1'b0;
    tick();

    // basic ramp, with a stray start in RUN and one in COOLDOWN
    do_start(20, 5);
    for (int k = 0; k < 5; k++) period(1000, 1, 1, (k == 2) ? 500 : -1);
    wait_idle(1, HOLD / 2);

    // saturation
    do_start(200, 4);
    for (int k = 0; k < 4; k++) period(1000, 1, 1, -1);
    wait_idle(1, -1);

    // period tracking with a short glitch interval
    do_start(10, 8);
    period(1000, 1, 1, -1);
    period(1000, 1, 1, -1);
    period(1100, 1, 1, -1);
    period(1100, 1, 1, -1);
    period(150, 0, 1, -1);
    for (int k = 0; k < 4; k++) period(1100, 1, 1, -1);
    wait_idle(1, -1);

    // feedback loss: last edge 300 cycles before start
    period(300, 0, 1, -1);
    do_start(5, 20);
    for (int k = 0; k < 7; k++) period(1000, 1, 0, -1);
    while (since_rise < 7990) tick();
    chk("loss_fault_not_yet", int'(fault), 0);
    chk("loss_enable_still_on", int'(enable), 1);
    while (since_rise < 8010) tick();
    chk("loss_fault_set", int'(fault), 1);
    chk("loss_enable_off", int'(enable), 0);
    chk("loss_busy", int'(busy), 1);
    wait_idle(0, -1);
    chk("loss_fault_sticky", int'(fault), 1);

    // reset mid-burst, simultaneous with start
    do_start(30, 10);
    for (int k = 0; k < 3; k++) period(900, 1, 1, -1);
    period(100, 0, 1, -1);
    chk("pre_rst_enable", int'(enable), 1);
    chk("pre_rst_period", int'(period_value), 900);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk("midrst_enable", int'(enable), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_load", int'(load), 0);
    chk("midrst_phase", int'(phase_shift), 0);
    chk("midrst_period", int'(period_value), DEFP);
    rst   = 1'b0;
    start = 1'b0;
    since_rise = 100000;
    exp_valid  = 0;
    tick();
    chk("rst_start_ignored", int'(busy), 0);
    for (int k = 0; k < 20; k++) tick();

    // ramp_cycles = 0 behaves as a single-period burst
    do_start(1, 0);
    period(1000, 1, 1, -1);
    wait_idle(1, -1);

    tick();
    tick();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
